// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: FSM state type and default widths.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int TIMER_WIDTH = 16;
    localparam int TIMER_PSC_W = 8;

endpackage

// File: rtl/timer_core_if.sv
// Command/configuration/status bundle between the timer and its user.
// Optional PWM signals (cmp_val, pwm_out) exist only when TIMER_PWM_EN is defined.
interface timer_core_if #(
    parameter int WIDTH = timer_pkg::TIMER_WIDTH,
    parameter int PSC_W = timer_pkg::TIMER_PSC_W
);
    logic             ce;
    logic             load;
    logic [WIDTH-1:0] reload_val;
    logic [PSC_W-1:0] psc_div;
    logic             auto_reload;
    logic             stop;
    logic             irq_clr;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expire;
    logic             irq;
`ifdef TIMER_PWM_EN
    logic [WIDTH-1:0] cmp_val;
    logic             pwm_out;

    modport master (output ce, load, reload_val, psc_div, auto_reload, stop, irq_clr, cmp_val,
                    input  count, busy, expire, irq, pwm_out);
    modport slave  (input  ce, load, reload_val, psc_div, auto_reload, stop, irq_clr, cmp_val,
                    output count, busy, expire, irq, pwm_out);
`else
    modport master (output ce, load, reload_val, psc_div, auto_reload, stop, irq_clr,
                    input  count, busy, expire, irq);
    modport slave  (input  ce, load, reload_val, psc_div, auto_reload, stop, irq_clr,
                    output count, busy, expire, irq);
`endif
endinterface

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits one tick every psc_div+1 enabled cycles.
// The >= compare lets a lowered psc_div take effect without a long wrap.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PSC_W = TIMER_PSC_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc_div,
    output logic             tick
);

    logic [PSC_W-1:0] psc_reg;

    assign tick = en && (psc_reg >= psc_div);

    // Prescaler counter: cleared by a command, wraps on tick, holds while disabled.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            psc_reg <= '0;
        end else if (clr) begin
            psc_reg <= '0;
        end else if (tick) begin
            psc_reg <= '0;
        end else if (en) begin
            psc_reg <= psc_reg + 1'b1;
        end
    end

endmodule

// File: rtl/timer_core.sv
// Down-counting interval timer with one-shot / periodic modes and sticky irq.
// Optional feature macro: TIMER_PWM_EN adds a registered compare output pwm_out.
module timer_core
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH,
    parameter int PSC_W = TIMER_PSC_W
) (
    input  logic         clk,
    input  logic         clr_n,
    timer_core_if.slave  bus
);

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic             expire_reg;
    logic             irq_reg;
    logic             tick;
    logic             irq_set;

    // Load and stop both restart the prescaler phase; they also override any tick.
    timer_prescaler #(.PSC_W(PSC_W)) u_psc (
        .clk     (clk),
        .clr_n   (clr_n),
        .en      ((state_reg == RUN) && bus.ce),
        .clr     (bus.load || bus.stop),
        .psc_div (bus.psc_div),
        .tick    (tick)
    );

    assign irq_set = tick && !bus.load && !bus.stop && (count_reg == '0);

    // FSM and counter: priority load > stop > tick; expire is a one-cycle pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            expire_reg <= 1'b0;
        end else begin
            expire_reg <= 1'b0;
            if (bus.load) begin
                count_reg <= bus.reload_val;
                state_reg <= RUN;
            end else if (bus.stop) begin
                state_reg <= IDLE;
            end else if (tick) begin
                if (count_reg != '0) begin
                    count_reg <= count_reg - 1'b1;
                end else begin
                    expire_reg <= 1'b1;
                    if (bus.auto_reload) begin
                        count_reg <= bus.reload_val;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            end
        end
    end

    // Sticky interrupt: a set in the same cycle as irq_clr wins.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            irq_reg <= 1'b0;
        end else if (irq_set) begin
            irq_reg <= 1'b1;
        end else if (bus.irq_clr) begin
            irq_reg <= 1'b0;
        end
    end

    assign bus.count  = count_reg;
    assign bus.busy   = (state_reg == RUN);
    assign bus.expire = expire_reg;
    assign bus.irq    = irq_reg;

`ifdef TIMER_PWM_EN
    logic pwm_reg;

    // PWM: high while running and the count is below the compare value.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pwm_reg <= 1'b0;
        end else begin
            pwm_reg <= (state_reg == RUN) && (count_reg < bus.cmp_val);
        end
    end

    assign bus.pwm_out = pwm_reg;
`endif

endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: cycle-by-cycle comparison against an
// elapsed-cycle model, plus hand-computed checks for each scenario.
// Define TIMER_PWM_EN to also exercise the PWM output.
module tb_timer_core;

    logic clk = 1'b0;
    logic clr_n;

    always #5 clk = ~clk;

    timer_core_if #(.WIDTH(16), .PSC_W(8)) bus ();

    timer_core #(.WIDTH(16), .PSC_W(8)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: time since (re)start measured in enabled cycles; count and expire
    // follow from count = N - e/(P+1) and expire when e reaches (N+1)*(P+1).
    bit run_m;
    int base_m, e_m, cnt_m;
    bit exp_m, irq_m, pwm_m, set_m;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            run_m = 0; base_m = 0; e_m = 0; cnt_m = 0;
            exp_m = 0; irq_m = 0; pwm_m = 0;
        end else begin
`ifdef TIMER_PWM_EN
            pwm_m = run_m && (cnt_m < int'(bus.cmp_val));
`endif
            set_m = 0;
            exp_m = 0;
            if (bus.load) begin
                base_m = int'(bus.reload_val); e_m = 0; run_m = 1; cnt_m = base_m;
            end else if (bus.stop) begin
                run_m = 0;
            end else if (run_m && bus.ce) begin
                e_m++;
                if (e_m == (base_m + 1) * (int'(bus.psc_div) + 1)) begin
                    exp_m = 1; set_m = 1;
                    if (bus.auto_reload) begin
                        base_m = int'(bus.reload_val); e_m = 0;
                    end else begin
                        run_m = 0;
                    end
                end
                cnt_m = run_m ? base_m - e_m / (int'(bus.psc_div) + 1) : 0;
            end
            if (set_m) irq_m = 1;
            else if (bus.irq_clr) irq_m = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (clr_n && chk_on) begin
            chk("cyc_count",  int'(bus.count),  cnt_m);
            chk("cyc_busy",   int'(bus.busy),   int'(run_m));
            chk("cyc_expire", int'(bus.expire), int'(exp_m));
            chk("cyc_irq",    int'(bus.irq),    int'(irq_m));
`ifdef TIMER_PWM_EN
            chk("cyc_pwm",    int'(bus.pwm_out), int'(pwm_m));
`endif
        end
    end

    // Issue a one-cycle load; returns at the negedge following the load edge.
    task automatic do_load(input int n, input int p, input bit ar);
        bus.reload_val  = 16'(n);
        bus.psc_div     = 8'(p);
        bus.auto_reload = ar;
        bus.load        = 1'b1;
        @(negedge clk);
        bus.load        = 1'b0;
    endtask

    int n_exp, first_k, n_hi;

    initial begin
        clr_n = 1'b0;
        bus.ce = 1'b1; bus.load = 0; bus.reload_val = '0; bus.psc_div = '0;
        bus.auto_reload = 0; bus.stop = 0; bus.irq_clr = 0;
`ifdef TIMER_PWM_EN
        bus.cmp_val = '0;
`endif
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_count",  int'(bus.count), 0);
        chk("rst_busy",   int'(bus.busy), 0);
        chk("rst_expire", int'(bus.expire), 0);
        chk("rst_irq",    int'(bus.irq), 0);

        // One-shot, N=3, P=0
        do_load(3, 0, 0);
        chk("os_count_k0", int'(bus.count), 3);
        chk("os_busy_k0",  int'(bus.busy), 1);
        @(negedge clk); chk("os_count_k1", int'(bus.count), 2);
        @(negedge clk); chk("os_count_k2", int'(bus.count), 1);
        @(negedge clk); chk("os_count_k3", int'(bus.count), 0);
        chk("os_expire_k3", int'(bus.expire), 0);
        @(negedge clk);
        chk("os_expire_k4", int'(bus.expire), 1);
        chk("os_busy_k4",   int'(bus.busy), 0);
        chk("os_irq_k4",    int'(bus.irq), 1);
        chk("os_count_k4",  int'(bus.count), 0);
        @(negedge clk); chk("os_expire_k5", int'(bus.expire), 0);

        // Periodic, N=2, P=1: period 6
        do_load(2, 1, 1);
        n_exp = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (bus.expire) n_exp++;
            if (k == 6) chk("per_expire_k6", int'(bus.expire), 1);
            if (k == 5) chk("per_expire_k5", int'(bus.expire), 0);
        end
        chk("per_expire_cnt", n_exp, 4);
        bus.irq_clr = 1'b1;
        @(negedge clk);                       // k=25
        bus.irq_clr = 1'b0;
        chk("per_irq_cleared", int'(bus.irq), 0);
        repeat (4) @(negedge clk);            // k=29
        bus.irq_clr = 1'b1;                   // sampled with the k=30 set
        @(negedge clk);
        bus.irq_clr = 1'b0;
        chk("per_set_wins_exp", int'(bus.expire), 1);
        chk("per_set_wins_irq", int'(bus.irq), 1);

        // Stop at count=4, then restart with N=7
        do_load(10, 0, 0);
        repeat (6) @(negedge clk);
        chk("stp_count_pre", int'(bus.count), 4);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stp_count_held", int'(bus.count), 4);
        chk("stp_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        chk("stp_count_still", int'(bus.count), 4);
        do_load(7, 0, 0);
        chk("rst7_count", int'(bus.count), 7);
        chk("rst7_busy",  int'(bus.busy), 1);
        first_k = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.expire && first_k < 0) first_k = k;
        end
        chk("rst7_expire_at", first_k, 8);

        // ce gating: 10 frozen cycles shift expire from k=6 to k=16
        do_load(5, 0, 0);
        repeat (2) @(negedge clk);
        bus.ce = 1'b0;
        repeat (10) @(negedge clk);
        chk("ce_count_frozen", int'(bus.count), 3);
        chk("ce_busy", int'(bus.busy), 1);
        bus.ce = 1'b1;
        first_k = -1;
        for (int k = 13; k <= 30; k++) begin
            @(negedge clk);
            if (bus.expire && first_k < 0) first_k = k;
        end
        chk("ce_expire_at", first_k, 16);

`ifdef TIMER_PWM_EN
        // PWM: N=9 periodic, cmp=4 -> 4 of 10 high; cmp=0 -> always low
        bus.cmp_val = 16'd4;
        do_load(9, 0, 1);
        repeat (12) @(negedge clk);
        n_hi = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.pwm_out) n_hi++;
        end
        chk("pwm_duty4", n_hi, 4);
        bus.cmp_val = 16'd0;
        repeat (2) @(negedge clk);
        n_hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.pwm_out) n_hi++;
        end
        chk("pwm_duty0", n_hi, 0);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
`endif

        // Asynchronous reset mid-run at count=5
        do_load(9, 0, 0);
        repeat (4) @(negedge clk);
        chk("ar_count_pre", int'(bus.count), 5);
        #2;
        clr_n = 1'b0;
        #1;
        chk("ar_count", int'(bus.count), 0);
        chk("ar_busy",  int'(bus.busy), 0);
        chk("ar_irq",   int'(bus.irq), 0);
        chk("ar_expire", int'(bus.expire), 0);
        @(negedge clk);
        clr_n = 1'b1;
        n_exp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.expire) n_exp++;
        end
        chk("ar_no_expire", n_exp, 0);
        chk("ar_idle", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_core.md
# timer_core

Programmable down-counting interval timer built for the timer datapath on a single clock. It takes a start/load command, divides the clock through a prescaler, and counts a loaded value down to zero. On reaching zero it emits a one-cycle expire pulse and sets a sticky interrupt flag. It either stops (one-shot) or reloads (periodic). It is the consumer/driver side of the flop-level storage: it reads configuration inputs and drives timing events to the rest of the design.

## Interface
- WIDTH, default 16: width of the counter and the reload value.
- PSC_W, default 8: width of the prescaler divide field.
- clk  in  1  system clock; rising-edge active.
- clr_n  in  1  asynchronous, active-low reset.
- ce  in  1  count enable; low freezes the prescaler and the counter.
- load  in  1  single-cycle start command; captures reload_val.
- reload_val  in  WIDTH  start/reload count N.
- psc_div  in  PSC_W  prescale value P; one tick every P+1 enabled cycles.
- auto_reload  in  1  1 = periodic mode, 0 = one-shot mode.
- stop  in  1  abort the run; the count is held.
- irq_clr  in  1  clears irq.
- count  out  WIDTH  current count value.
- busy  out  1  high while the state is RUN.
- expire  out  1  one-cycle pulse at the end of each period.
- irq  out  1  sticky expire flag.
- cmp_val  in  WIDTH  PWM compare value (TIMER_PWM_EN only).
- pwm_out  out  1  PWM output (TIMER_PWM_EN only).

## Operation
- **States:** IDLE and RUN. Reset state is IDLE.
- **Reset values:** count=0, prescaler=0, busy=0, expire=0, irq=0, pwm_out=0.
- **Command priority within a cycle:** load > stop > tick.
- **load (any state):**
  - count <= reload_val.
  - prescaler <= 0.
  - state <= RUN.
- **stop (without load):** state <= IDLE; count is held; prescaler <= 0.
- **Tick:** generated when state=RUN, ce=1 and prescaler >= psc_div.
  - On a tick, the prescaler wraps to 0; otherwise it increments while RUN and ce=1.
  - The >= compare covers psc_div being lowered mid-count.
- **On a tick with count != 0:** count <= count-1.
- **On a tick with count == 0:**
  - expire <= 1 for the next cycle only.
  - irq <= 1.
  - If auto_reload=1: count <= reload_val (value sampled at that edge) and the state stays RUN.
  - If auto_reload=0: state <= IDLE and count stays 0.
- **reload_val = 0 in periodic mode:** expire fires on every tick.
- **irq:** cleared by irq_clr; if a set and irq_clr occur in the same cycle, the set wins.
- **ce low in RUN:** the counter and prescaler freeze; the state stays RUN.
- **Asynchronous reset mid-run:** all registers return to reset values immediately; no expire is generated.

## Timing
- **busy:** rises on the edge that samples load (one cycle of latency).
- **expire latency:** with P=0 and ce=1 held, expire is high in the (N+1)th cycle after the load edge.
- **Period:** (N+1)*(P+1) enabled clk cycles, in both modes.
- **Periodic mode:** expire is high for 1 cycle per period, with no gap cycle at reload.
- **Registered outputs:** count, expire, irq and busy are all registered; there are no combinational paths from inputs to outputs.
- **load during RUN:** restarts the period cleanly; a tick in the same cycle is discarded.

## Configuration
- **TIMER_PWM_EN defined:**
  - Ports cmp_val and pwm_out exist.
  - pwm_out = registered (state==RUN && count < cmp_val), updated every cycle.
  - pwm_out is 0 in IDLE.
  - cmp_val=0 gives a constant 0; cmp_val > N gives a constant 1 while RUN.
- **TIMER_PWM_EN undefined:** both ports and the compare logic are absent; all other behaviour is identical.

## Structure
- **Shared package timer_pkg:**
  - state enum (IDLE, RUN).
  - default WIDTH and PSC_W localparams.
- **Sub-module timer_prescaler:**
  - Inputs: clk, clr_n, en, clr, psc_div.
  - Output: tick.
  - Owns the prescaler counter and the >= wrap compare.
- **timer_core:** holds the FSM, counter, irq, and the optional PWM logic.

## Test plan
- **Reset:** assert clr_n=0 mid-run with count=5 -> all outputs 0 immediately; after release, state IDLE and no expire.
- **One-shot, no prescale:** N=3, P=0, auto_reload=0, load -> count 3,2,1,0; expire high exactly 4 cycles after the load edge; then busy=0, irq=1, count=0.
- **Periodic with prescale:** N=2, P=1, auto_reload=1 -> expire every 6 cycles for 4 periods; irq_clr pulsed on the same cycle as an irq set -> irq stays 1.
- **Stop, then restart:** stop at count=4 -> IDLE with count held at 4; load with N=7 -> count=7, busy=1, and a full period follows.
- **ce gating:** deassert ce for 10 cycles mid-run -> count and prescaler frozen; the expire time shifts by exactly 10 cycles.
- **PWM (TIMER_PWM_EN):** N=9, P=0, periodic, cmp_val=4 -> pwm_out high for 4 of every 10 cycles; cmp_val=0 -> pwm_out stays 0.
